// File: rtl/async_fifo.sv
// Single-clock FIFO with first-word fall-through read data and registered
// full / almost-full / empty / almost-empty flags.
module async_fifo #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             awfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             arempty
);

    localparam int unsigned PW    = ASIZE + 1;
    localparam int unsigned DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_nxt;
    logic [PW-1:0] rptr_nxt;
    logic [PW-1:0] count_nxt;
    logic          w_ok;
    logic          r_ok;
    logic          wfull_nxt;
    logic          awfull_nxt;
    logic          rempty_nxt;
    logic          arempty_nxt;

    // Accept decisions use the registered flags only, never same-cycle inputs.
    always_comb begin
        w_ok        = winc & ~wfull;
        r_ok        = rinc & ~rempty;
        wptr_nxt    = wptr + PW'(w_ok);
        rptr_nxt    = rptr + PW'(r_ok);
        count_nxt   = wptr_nxt - rptr_nxt;
        rempty_nxt  = (count_nxt == PW'(0));
        arempty_nxt = (count_nxt == PW'(1));
        wfull_nxt   = (count_nxt == PW'(DEPTH));
        awfull_nxt  = (count_nxt == PW'(DEPTH - 1));
    end

    // Pointers and flags; flags describe occupancy after this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            arempty <= 1'b0;
            wfull   <= 1'b0;
            awfull  <= 1'b0;
        end else begin
            wptr    <= wptr_nxt;
            rptr    <= rptr_nxt;
            rempty  <= rempty_nxt;
            arempty <= arempty_nxt;
            wfull   <= wfull_nxt;
            awfull  <= awfull_nxt;
        end
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_ok) begin
            mem[wptr[ASIZE-1:0]] <= wdata;
        end
    end

    // Head word is presented combinationally (fall-through).
    assign rdata = mem[rptr[ASIZE-1:0]];

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo at DSIZE=32, ASIZE=2 (depth 4).
module tb_async_fifo;

    localparam int unsigned DSIZE = 32;
    localparam int unsigned ASIZE = 2;

    logic             clk;
    logic             rst_n;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             awfull;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             arempty;

    int n_checks;
    int n_pass;
    logic [DSIZE-1:0] exp_q [$];

    async_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .winc    (winc),
        .wdata   (wdata),
        .wfull   (wfull),
        .awfull  (awfull),
        .rinc    (rinc),
        .rdata   (rdata),
        .rempty  (rempty),
        .arempty (arempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [DSIZE-1:0] got,
                         input logic [DSIZE-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, got, exp);
    endtask

    task automatic check_flags(input string name, input logic e_empty,
                               input logic e_aempty, input logic e_full,
                               input logic e_afull);
        check({name, ".rempty"},  DSIZE'(rempty),  DSIZE'(e_empty));
        check({name, ".arempty"}, DSIZE'(arempty), DSIZE'(e_aempty));
        check({name, ".wfull"},   DSIZE'(wfull),   DSIZE'(e_full));
        check({name, ".awfull"},  DSIZE'(awfull),  DSIZE'(e_afull));
    endtask

    // One clock of stimulus; push expected data when the write should be accepted.
    task automatic cycle(input logic w, input logic [DSIZE-1:0] d,
                         input logic r, input logic push);
        winc  = w;
        wdata = d;
        rinc  = r;
        if (push) exp_q.push_back(d);
        @(posedge clk);
        #1;
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    // Monitor: a pop about to be accepted must present the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rinc && !rempty) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL pop_unexpected: got %h, required no data", rdata);
            end else begin
                check("rdata_pop", rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        int occ;
        int nxt;
        int k;
        n_checks = 0;
        n_pass   = 0;
        winc     = 1'b0;
        rinc     = 1'b0;
        wdata    = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single write then pop.
        cycle(1'b1, 32'hA5A5_0001, 1'b0, 1'b1);
        check_flags("one_write", 1'b0, 1'b1, 1'b0, 1'b0);
        check("one_write.rdata", rdata, 32'hA5A5_0001);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_flags("one_read", 1'b1, 1'b0, 1'b0, 1'b0);

        // Fill to full, overflow write ignored, drain.
        cycle(1'b1, 32'h1, 1'b0, 1'b1);
        cycle(1'b1, 32'h2, 1'b0, 1'b1);
        cycle(1'b1, 32'h3, 1'b0, 1'b1);
        check_flags("three", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h4, 1'b0, 1'b1);
        check_flags("full", 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h5, 1'b0, 1'b0);
        check_flags("overflow", 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);
        check_flags("drained", 1'b1, 1'b0, 1'b0, 1'b0);
        check("drained.q", DSIZE'(exp_q.size()), '0);

        // Underflow attempts, then a write.
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
        check_flags("underflow", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h77, 1'b0, 1'b1);
        check_flags("after_underflow", 1'b0, 1'b1, 1'b0, 1'b0);
        check("after_underflow.rdata", rdata, 32'h77);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Full with simultaneous write+read: read wins, write dropped.
        cycle(1'b1, 32'h11, 1'b0, 1'b1);
        cycle(1'b1, 32'h12, 1'b0, 1'b1);
        cycle(1'b1, 32'h13, 1'b0, 1'b1);
        cycle(1'b1, 32'h14, 1'b0, 1'b1);
        check_flags("full2", 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h99, 1'b1, 1'b0);
        check_flags("full_wr", 1'b0, 1'b0, 1'b0, 1'b1);
        check("full_wr.rdata", rdata, 32'h12);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
        check_flags("drained2", 1'b1, 1'b0, 1'b0, 1'b0);

        // Stream 0..19 with occupancy held between 2 and 3.
        cycle(1'b1, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 32'd1, 1'b0, 1'b1);
        check("stream.single_head", rdata, 32'd0);
        occ = 2;
        nxt = 2;
        k   = 0;
        while (nxt < 20 && k < 200) begin
            case (k % 4)
                0, 3: begin cycle(1'b1, DSIZE'(nxt), 1'b1, 1'b1); nxt++; end
                1:    begin cycle(1'b1, DSIZE'(nxt), 1'b0, 1'b1); nxt++; occ++; end
                default: begin cycle(1'b0, '0, 1'b1, 1'b0); occ--; end
            endcase
            k++;
        end
        check("stream.awfull", DSIZE'(awfull), DSIZE'(occ == 3));
        while (occ > 0) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            occ--;
        end
        check_flags("stream_end", 1'b1, 1'b0, 1'b0, 1'b0);
        check("stream_end.q", DSIZE'(exp_q.size()), '0);

        // Asynchronous reset between edges with data held.
        cycle(1'b1, 32'hAA, 1'b0, 1'b1);
        cycle(1'b1, 32'hBB, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_flags("async_reset", 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.delete();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 32'h5, 1'b0, 1'b1);
        check_flags("post_reset", 1'b0, 1'b1, 1'b0, 1'b0);
        check("post_reset.rdata", rdata, 32'h5);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_flags("post_reset_empty", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/async_fifo.md
ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 Parameter DSIZE, default 8: data word width in bits.
REQ-002 Parameter ASIZE, default 4: address width; depth = 2**ASIZE words.
REQ-003 Single clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 winc  input  1  write request; word accepted at edge when winc=1 and wfull=0.
REQ-007 wdata  input  DSIZE  write data, sampled at accepting edge.
REQ-008 wfull  output  1  FIFO holds 2**ASIZE words.
REQ-009 awfull  output  1  almost full: FIFO holds exactly 2**ASIZE-1 words.
REQ-010 rinc  input  1  read/pop request; head word removed at edge when rinc=1 and rempty=0.
REQ-011 rdata  output  DSIZE  head-of-FIFO word (first-word fall-through).
REQ-012 rempty  output  1  FIFO holds 0 words.
REQ-013 arempty  output  1  almost empty: FIFO holds exactly 1 word.

Function
REQ-014 Storage SHALL be a 2**ASIZE x DSIZE array; array contents are not reset.
REQ-015 Write and read pointers SHALL be ASIZE+1 bits wide (extra wrap bit); low ASIZE bits address the array; pointers wrap from 2**(ASIZE+1)-1 to 0.
REQ-016 Accepted write: mem[wptr] <= wdata, wptr increments by 1 at same edge.
REQ-017 Accepted read: rptr increments by 1; no other effect.
REQ-018 rdata SHALL be combinational mem[rptr low bits]; valid whenever rempty=0; value when empty is don't-care.
REQ-019 Occupancy = wptr - rptr modulo 2**(ASIZE+1); range 0..2**ASIZE.
REQ-020 wfull, awfull, rempty, arempty SHALL be registered and reflect occupancy after the current edge: a write into an empty FIFO deasserts rempty and shows the word on rdata in the first cycle after that edge (1-cycle latency).
REQ-021 winc while wfull=1 SHALL be ignored (no array write, no pointer change, no error flag).
REQ-022 rinc while rempty=1 SHALL be ignored (pointer unchanged).
REQ-023 Simultaneous winc and rinc, neither blocked: both happen; occupancy and flags unchanged; when occupancy is 1 the new word becomes head.
REQ-024 Simultaneous winc and rinc when full: read happens, write ignored; occupancy becomes 2**ASIZE-1.
REQ-025 Simultaneous winc and rinc when empty: write happens, read ignored; occupancy becomes 1.
REQ-026 Flags are gated by the flag values present at the edge, not by same-cycle inputs.
REQ-027 Data SHALL leave in exact write order across any number of pointer wraps.

Reset
REQ-028 rst_n=0 SHALL immediately, without clock, set wptr=0, rptr=0, rempty=1, arempty=0, wfull=0, awfull=0.
REQ-029 Reset mid-operation discards all stored words; winc/rinc during reset are ignored.
REQ-030 First accepted operation is at the first rising edge with rst_n=1 at that edge.

Verification (DSIZE=32, ASIZE=2, depth 4)
REQ-031 Reset, then one write 0xA5A5_0001 -> after that edge rempty=0, arempty=1, rdata=0xA5A5_0001; rinc one cycle -> rempty=1, arempty=0.
REQ-032 Write 0x1,0x2,0x3 -> awfull=1 after third edge; write 0x4 -> wfull=1, awfull=0; fifth write 0x5 ignored; four reads return 0x1,0x2,0x3,0x4 then rempty=1.
REQ-033 rinc held on empty FIFO for 3 cycles, then write 0x77 -> rdata=0x77, rempty=0 (no pointer underflow).
REQ-034 Full FIFO, winc+rinc same cycle with wdata=0x99 -> head popped, 0x99 not stored, wfull=0, awfull=1.
REQ-035 Stream 20 words 0..19 with interleaved reads (occupancy 1-3), simultaneous winc/rinc on several cycles -> output sequence exactly 0..19 across pointer wraps.
REQ-036 Fill 2 words, pulse rst_n low asynchronously between edges -> flags return to reset values immediately; next write 0x5 reads back as 0x5.
